// File: rtl/dmem_wait_ctrl_if.sv
// Request/response bus between the core (master) and the wait-state data memory (slave).
// The core holds all request qualifiers stable until it sees the ready pulse.
interface dmem_wait_ctrl_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        stall;

    modport master (
        output req, we, be, addr, wdata,
        input  rdata, ready, err, stall
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output rdata, ready, err, stall
    );
endinterface

// File: rtl/dmem_wait_ctrl.sv
// Data memory with LATENCY wait states, per-byte write enables and error reporting.
// Latency: accept edge + LATENCY+1 cycles to the ready pulse; stall holds the pipeline until then.
// Backpressure: one access in flight; requests are not sampled again until the FSM is back in IDLE.
module dmem_wait_ctrl #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    dmem_wait_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        ready_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        l_we;
    logic [3:0]  l_be;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;

    logic [31:0] mem [DEPTH];

    logic        c_we;
    logic [3:0]  c_be;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        commit;
    logic        bad;
    logic [AW-1:0] widx;

    // With zero wait states the access commits on the accept edge, straight from the bus;
    // otherwise it commits from the copy taken at accept, so a dropped req cannot corrupt it.
    always_comb begin
        c_we    = l_we;
        c_be    = l_be;
        c_addr  = l_addr;
        c_wdata = l_wdata;
        if (state == IDLE) begin
            c_we    = bus.we;
            c_be    = bus.be;
            c_addr  = bus.addr;
            c_wdata = bus.wdata;
        end
        commit = ((state == IDLE) && bus.req && (LATENCY == 0)) ||
                 ((state == WAIT) && (cnt == 4'd1));
        bad    = (c_addr[1:0] != 2'b00) || ({2'b00, c_addr[31:2]} >= 32'(DEPTH));
        widx   = c_addr[AW+1:2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            l_we    <= 1'b0;
            l_be    <= 4'h0;
            l_addr  <= 32'h0;
            l_wdata <= 32'h0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        l_we    <= bus.we;
                        l_be    <= bus.be;
                        l_addr  <= bus.addr;
                        l_wdata <= bus.wdata;
                        cnt     <= 4'(LATENCY);
                        state   <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (commit) begin
                ready_q <= 1'b1;
                err_q   <= bad;
                if (!c_we)
                    rdata_q <= bad ? 32'h0 : mem[widx];
            end
        end
    end

    // Storage is deliberately not reset; a reset on the commit edge discards the write.
    always_ff @(posedge clk) begin
        if (!reset && commit && c_we && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i])
                    mem[widx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.stall = bus.req & ~ready_q;
endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Directed bench for dmem_wait_ctrl: a LATENCY=2 instance and a LATENCY=0 instance on one clock.
module tb_dmem_wait_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dmem_wait_ctrl_if bus2 ();
    dmem_wait_ctrl_if bus0 ();

    dmem_wait_ctrl #(.DEPTH(64), .LATENCY(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    dmem_wait_ctrl #(.DEPTH(64), .LATENCY(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access on the LATENCY=2 instance; lat is the cycle index of ready (-1 on timeout).
    task automatic acc2(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd,
                        output logic e, output int stalls, output logic st_rdy);
        @(posedge clk); #1;
        bus2.req = 1'b1; bus2.we = w; bus2.be = b; bus2.addr = a; bus2.wdata = d;
        lat = -1; stalls = 0; rd = 32'h0; e = 1'b0; st_rdy = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus2.ready) begin
                lat = n; rd = bus2.rdata; e = bus2.err; st_rdy = bus2.stall;
                break;
            end
            if (bus2.stall) stalls++;
        end
        @(posedge clk); #1;
        bus2.req = 1'b0;
    endtask

    int          lat, stalls, seen;
    logic [31:0] rd;
    logic        e, st;
    logic [3:0]  pat;

    initial begin
        reset = 1'b1;
        bus2.req = 1'b0; bus2.we = 1'b0; bus2.be = 4'h0; bus2.addr = 32'h0; bus2.wdata = 32'h0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.be = 4'h0; bus0.addr = 32'h0; bus0.wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'h0, bus2.ready}, 32'h0);
        chk("rst_err",   {31'h0, bus2.err},   32'h0);
        chk("rst_rdata", bus2.rdata, 32'h0);
        chk("rst_stall", {31'h0, bus2.stall}, 32'h0);
        chk("rst_ready0", {31'h0, bus0.ready}, 32'h0);

        // Full word write, then read back
        acc2(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, e, stalls, st);
        chk("wr_lat", 32'(lat), 32'd3);
        chk("wr_err", {31'h0, e}, 32'h0);
        chk("wr_stalls", 32'(stalls), 32'd3);
        chk("wr_stall_at_rdy", {31'h0, st}, 32'h0);
        chk("wr_no_rdata", rd, 32'h0);
        acc2(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, e, stalls, st);
        chk("rd_lat", 32'(lat), 32'd3);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_err", {31'h0, e}, 32'h0);
        repeat (2) @(negedge clk);
        chk("rd_held", bus2.rdata, 32'hDEADBEEF);
        chk("rd_ready_pulse", {31'h0, bus2.ready}, 32'h0);

        // Byte-lane write
        acc2(1'b1, 4'b0010, 32'h10, 32'h0000AB00, lat, rd, e, stalls, st);
        chk("be_err", {31'h0, e}, 32'h0);
        chk("be_rdata_kept", rd, 32'hDEADBEEF);
        acc2(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, e, stalls, st);
        chk("be_rd", rd, 32'hDEADABEF);

        // Errors: misaligned write, misaligned read, out of range read
        acc2(1'b1, 4'hF, 32'h13, 32'hFFFFFFFF, lat, rd, e, stalls, st);
        chk("mis_wr_err", {31'h0, e}, 32'h1);
        chk("mis_wr_lat", 32'(lat), 32'd3);
        acc2(1'b0, 4'h0, 32'h12, 32'h0, lat, rd, e, stalls, st);
        chk("mis_rd_err", {31'h0, e}, 32'h1);
        chk("mis_rd_data", rd, 32'h0);
        acc2(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, e, stalls, st);
        chk("mis_unchanged", rd, 32'hDEADABEF);
        chk("mis_after_err", {31'h0, e}, 32'h0);
        acc2(1'b0, 4'h0, 32'h100, 32'h0, lat, rd, e, stalls, st);
        chk("oor_err", {31'h0, e}, 32'h1);
        chk("oor_data", rd, 32'h0);
        acc2(1'b1, 4'hF, 32'h100, 32'h55555555, lat, rd, e, stalls, st);
        chk("oor_wr_err", {31'h0, e}, 32'h1);
        acc2(1'b0, 4'h0, 32'h0, 32'h0, lat, rd, e, stalls, st);
        chk("oor_no_alias", {31'h0, e}, 32'h0);

        // be=0 write is a legal no-op
        acc2(1'b1, 4'h0, 32'h10, 32'h0, lat, rd, e, stalls, st);
        chk("be0_err", {31'h0, e}, 32'h0);
        chk("be0_lat", 32'(lat), 32'd3);
        acc2(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, e, stalls, st);
        chk("be0_unchanged", rd, 32'hDEADABEF);

        // Reset in WAIT aborts a pending write
        acc2(1'b1, 4'hF, 32'h20, 32'hCAFEF00D, lat, rd, e, stalls, st);
        @(posedge clk); #1;
        bus2.req = 1'b1; bus2.we = 1'b1; bus2.be = 4'hF; bus2.addr = 32'h20; bus2.wdata = 32'h12345678;
        @(posedge clk); #1;
        reset = 1'b1; bus2.req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus2.ready) seen++;
        end
        chk("abort_no_ready", 32'(seen), 32'd0);
        chk("abort_rdata_rst", bus2.rdata, 32'h0);
        acc2(1'b0, 4'h0, 32'h20, 32'h0, lat, rd, e, stalls, st);
        chk("abort_mem", rd, 32'hCAFEF00D);
        chk("abort_rd_lat", 32'(lat), 32'd3);

        // LATENCY=0 instance: one-cycle response and one accept per two cycles
        @(posedge clk); #1;
        bus0.req = 1'b1; bus0.we = 1'b1; bus0.be = 4'hF; bus0.addr = 32'h0; bus0.wdata = 32'h11223344;
        @(negedge clk);
        chk("l0_c0_ready", {31'h0, bus0.ready}, 32'h0);
        chk("l0_c0_stall", {31'h0, bus0.stall}, 32'h1);
        @(negedge clk);
        chk("l0_c1_ready", {31'h0, bus0.ready}, 32'h1);
        chk("l0_c1_err", {31'h0, bus0.err}, 32'h0);
        @(posedge clk); #1;
        bus0.req = 1'b0;
        @(posedge clk); #1;
        bus0.req = 1'b1; bus0.we = 1'b0;
        pat = 4'h0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            pat[n] = bus0.ready;
        end
        chk("l0_pattern", {28'h0, pat}, 32'h0000000A);
        chk("l0_rdata", bus0.rdata, 32'h11223344);
        @(posedge clk); #1;
        bus0.req = 1'b0;

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
